// File: rtl/serial_subtractor_if.sv
// Operand and result valid/ready handshakes for the bit-serial subtractor.
// master drives operands and result acceptance; slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             brow_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] diff_out;
  logic             brow_out;

  modport master (
    output start_valid, a_in, b_in, brow_in, res_ready,
    input  start_ready, res_valid, diff_out, brow_out
  );

  modport slave (
    input  start_valid, a_in, b_in, brow_in, res_ready,
    output start_ready, res_valid, diff_out, brow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first,
// borrow kept in a flop, parallel result behind a valid/ready handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus,
  output logic                busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d;
  logic             bo;
  logic             last;

  // Full-subtractor cell on the current LSB pair.
  always_comb begin
    d      = a_sr[0] ^ b_sr[0] ^ borrow;
    bo     = (~a_sr[0] & b_sr[0]) |
             (~(a_sr[0] ^ b_sr[0]) & borrow);
    res_nx = res_sr >> 1;
    res_nx[WIDTH-1] = d;
    last   = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_valid) state_d = SHIFT;
      SHIFT:   if (last)            state_d = DONE;
      DONE:    if (bus.res_ready)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign busy            = (state_q == SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr         <= '0;
      b_sr         <= '0;
      res_sr       <= '0;
      cnt          <= '0;
      borrow       <= 1'b0;
      bus.diff_out <= '0;
      bus.brow_out <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            a_sr   <= bus.a_in;
            b_sr   <= bus.b_in;
            borrow <= bus.brow_in;
            cnt    <= '0;
            res_sr <= '0;
          end
        end
        SHIFT: begin
          res_sr <= res_nx;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= bo;
          cnt    <= cnt + CW'(1);
          if (last) begin
            bus.diff_out <= res_nx;
            bus.brow_out <= bo;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor at WIDTH=8
// plus an exhaustive back-to-back sweep at WIDTH=3.
module tb_serial_subtractor;
  logic clk;
  logic rst_n;
  logic busy8;
  logic busy3;
  int   checks;
  int   errors;

  serial_subtractor_if #(.WIDTH(8)) s8 ();
  serial_subtractor_if #(.WIDTH(3)) s3 ();

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s8),
    .busy  (busy8)
  );

  serial_subtractor #(.WIDTH(3)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s3),
    .busy  (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] diff;
    logic       bo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input vec_t v, input string tag);
    int cyc;
    s8.a_in        = v.a;
    s8.b_in        = v.b;
    s8.brow_in     = v.bi;
    s8.start_valid = 1'b1;
    tick();
    s8.start_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy8), 1);
    cyc = 0;
    while (!s8.res_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 8);
    chk({tag, "_diff"}, 32'(s8.diff_out), 32'(v.diff));
    chk({tag, "_brow"}, 32'(s8.brow_out), 32'(v.bo));
    s8.res_ready = 1'b1;
    tick();
    s8.res_ready = 1'b0;
    chk({tag, "_idle"}, 32'({s8.start_ready, s8.res_valid}), 2);
  endtask

  vec_t vecs [8];

  initial begin
    int cyc;
    int seen;
    vec_t v;
    checks = 0;
    errors = 0;

    vecs[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0};
    vecs[1] = '{8'd5,   8'd10,  1'b0, 8'd251, 1'b1};
    vecs[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
    vecs[3] = '{8'd200, 8'd55,  1'b0, 8'd145, 1'b0};
    vecs[4] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
    vecs[5] = '{8'd255, 8'd0,   1'b0, 8'd255, 1'b0};
    vecs[6] = '{8'd0,   8'd255, 1'b0, 8'd1,   1'b1};
    vecs[7] = '{8'd128, 8'd1,   1'b1, 8'd126, 1'b0};

    rst_n = 1'b0;
    s8.start_valid = 1'b0;
    s8.a_in = '0;
    s8.b_in = '0;
    s8.brow_in = 1'b0;
    s8.res_ready = 1'b0;
    s3.start_valid = 1'b0;
    s3.a_in = '0;
    s3.b_in = '0;
    s3.brow_in = 1'b0;
    s3.res_ready = 1'b0;
    tick();
    tick();
    chk("rst_start_ready", 32'(s8.start_ready), 1);
    chk("rst_res_valid", 32'(s8.res_valid), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_diff", 32'(s8.diff_out), 0);
    chk("rst_brow", 32'(s8.brow_out), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held, new starts ignored.
    s8.a_in = 8'd100;
    s8.b_in = 8'd37;
    s8.brow_in = 1'b0;
    s8.start_valid = 1'b1;
    tick();
    s8.start_valid = 1'b0;
    cyc = 0;
    while (!s8.res_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("bp_lat", cyc, 8);
    for (int i = 0; i < 20; i++) begin
      s8.start_valid = i[0];
      s8.a_in = 8'(i * 7);
      s8.b_in = 8'(i * 3);
      tick();
      chk($sformatf("bp_hold%0d", i),
          32'({s8.res_valid, s8.start_ready, s8.diff_out, s8.brow_out}),
          32'({1'b1, 1'b0, 8'd63, 1'b0}));
    end
    s8.start_valid = 1'b1;
    s8.res_ready = 1'b1;
    tick();
    s8.start_valid = 1'b0;
    s8.res_ready = 1'b0;
    chk("bp_release",
        32'({s8.res_valid, s8.start_ready, busy8}), 32'(3'b010));
    tick();
    chk("bp_no_accept", 32'(busy8), 0);

    // Reset in the third SHIFT cycle aborts the operation.
    s8.a_in = 8'd77;
    s8.b_in = 8'd12;
    s8.brow_in = 1'b1;
    s8.start_valid = 1'b1;
    tick();
    s8.start_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("rmid_state",
        32'({s8.start_ready, s8.res_valid, busy8}), 32'(3'b100));
    chk("rmid_diff", 32'(s8.diff_out), 0);
    chk("rmid_brow", 32'(s8.brow_out), 0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s8.res_valid) seen++;
    end
    chk("rmid_no_result", seen, 0);

    // Operands flipped every cycle after accept.
    s8.a_in = 8'd200;
    s8.b_in = 8'd55;
    s8.brow_in = 1'b0;
    s8.start_valid = 1'b1;
    tick();
    s8.start_valid = 1'b0;
    cyc = 0;
    while (!s8.res_valid && cyc < 50) begin
      s8.a_in = ~s8.a_in;
      s8.b_in = ~s8.b_in;
      s8.brow_in = ~s8.brow_in;
      tick();
      cyc++;
    end
    chk("flip_lat", cyc, 8);
    chk("flip_diff", 32'(s8.diff_out), 145);
    chk("flip_brow", 32'(s8.brow_out), 0);
    s8.res_ready = 1'b1;
    tick();
    s8.res_ready = 1'b0;

    // Exhaustive WIDTH=3 sweep, back-to-back.
    for (int k = 0; k < 128; k++) begin
      logic [2:0] a3;
      logic [2:0] b3;
      logic       c3;
      logic [3:0] gold;
      a3 = 3'(k >> 4);
      b3 = 3'(k >> 1);
      c3 = k[0];
      gold = 4'(5'(a3) - 5'(b3) - 5'(c3));
      s3.a_in = a3;
      s3.b_in = b3;
      s3.brow_in = c3;
      s3.start_valid = 1'b1;
      tick();
      s3.start_valid = 1'b0;
      cyc = 0;
      while (!s3.res_valid && cyc < 20) begin
        tick();
        cyc++;
      end
      chk($sformatf("w3_lat_%0d", k), cyc, 3);
      chk($sformatf("w3_res_%0d", k),
          32'({s3.brow_out, s3.diff_out}), 32'(gold));
      s3.res_ready = 1'b1;
      tick();
      s3.res_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
